// File: rtl/pulse_peak_detector_if.sv
// ----------------------------------------------------------------------------
// pulse_peak_detector_if
// Event record channel of the pulse peak detector (valid/ready handshake).
//   event_valid   record valid (master -> slave)
//   event_ready   consumer accepts the record (slave -> master)
//   event_peak    signed peak amplitude
//   event_time    timestamp of the peak sample
//   event_width   samples above threshold, saturating
//   event_pileup  pile-up seen within the pulse
// ----------------------------------------------------------------------------
interface pulse_peak_detector_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 16,
  parameter int WID_W  = 8
);
  logic                     event_valid;
  logic                     event_ready;
  logic signed [DATA_W-1:0] event_peak;
  logic [TS_W-1:0]          event_time;
  logic [WID_W-1:0]         event_width;
  logic                     event_pileup;

  modport master (
    output event_valid, event_peak, event_time, event_width, event_pileup,
    input  event_ready
  );

  modport slave (
    input  event_valid, event_peak, event_time, event_width, event_pileup,
    output event_ready
  );
endinterface

// File: rtl/pulse_peak_detector.sv
// ----------------------------------------------------------------------------
// pulse_peak_detector
// Thresholds the filtered signed sample stream, tracks each pulse and emits
// one record per pulse (peak, peak timestamp, width, pile-up flag) through a
// one-deep valid/ready buffer. Records arriving while the buffer is full are
// dropped and counted.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   input_data  signed filtered sample, one per clock
//   threshold   signed trigger level, quasi-static
//   evt         record channel (pulse_peak_detector_if.master)
//   lost_count  records dropped on a full buffer, saturating
//
// Optional feature: define PULSE_PILEUP_DETECT_EN to build the falling-edge /
// pile-up tracking. Without it event_pileup is constant 0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a registered sample above threshold
// RISE   | inside a pulse: tracking peak, width, pile-up
// DEAD   | DEAD_TIME cycles after a pulse, input ignored
// ----------------------------------------------------------------------------
module pulse_peak_detector #(
  parameter int SIZE_FILTER_DATA = 13,
  parameter int DATA_W           = SIZE_FILTER_DATA + 3,
  parameter int TS_W             = 16,
  parameter int WID_W            = 8,
  parameter int DEAD_TIME        = 8,
  parameter int PILEUP_HYST      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic signed [DATA_W-1:0] threshold,
  pulse_peak_detector_if.master    evt,
  output logic [15:0]              lost_count
);

  typedef enum logic [1:0] {S_IDLE, S_RISE, S_DEAD} state_t;

  localparam int               CNT_W   = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [WID_W-1:0] WID_MAX = '1;

  state_t                   state_q;
  logic [CNT_W-1:0]         dead_cnt_q;
  logic [TS_W-1:0]          ts_q, ts_r_q, ts_d;
  logic signed [DATA_W-1:0] d_q;
  logic signed [DATA_W-1:0] peak_q;
  logic [TS_W-1:0]          time_q;
  logic [WID_W-1:0]         width_q;

  logic                     ev_valid_q;
  logic signed [DATA_W-1:0] ev_peak_q;
  logic [TS_W-1:0]          ev_time_q;
  logic [WID_W-1:0]         ev_width_q;
  logic [15:0]              lost_q;

  logic above;
  logic buf_free;

  // ts_r carries the value ts takes on the same edge, so a sample captured on
  // the first edge out of reset is stamped 1.
  assign ts_d     = ts_q + 1'b1;
  assign above    = d_q > threshold;
  assign buf_free = !ev_valid_q || evt.event_ready;

`ifdef PULSE_PILEUP_DETECT_EN
  localparam int EXT_W = DATA_W + 1;
  logic signed [DATA_W-1:0] d_prev_q;
  logic                     falling_q, pileup_q, ev_pileup_q;
  logic signed [EXT_W-1:0]  d_ext, prev_hyst;
  logic                     fall_now, pile_now;

  // Extended by one bit so d_prev + hysteresis cannot wrap near full scale.
  assign d_ext     = {d_q[DATA_W-1], d_q};
  assign prev_hyst = {d_prev_q[DATA_W-1], d_prev_q} + $signed(EXT_W'(PILEUP_HYST));
  assign fall_now  = d_q < d_prev_q;
  assign pile_now  = falling_q && (d_ext > prev_hyst);
  assign evt.event_pileup = ev_pileup_q;
`else
  assign evt.event_pileup = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      dead_cnt_q <= '0;
      ts_q       <= '0;
      ts_r_q     <= '0;
      d_q        <= '0;
      peak_q     <= '0;
      time_q     <= '0;
      width_q    <= '0;
      ev_valid_q <= 1'b0;
      ev_peak_q  <= '0;
      ev_time_q  <= '0;
      ev_width_q <= '0;
      lost_q     <= '0;
`ifdef PULSE_PILEUP_DETECT_EN
      d_prev_q    <= '0;
      falling_q   <= 1'b0;
      pileup_q    <= 1'b0;
      ev_pileup_q <= 1'b0;
`endif
    end else begin
      ts_q   <= ts_d;
      ts_r_q <= ts_d;
      d_q    <= input_data;
`ifdef PULSE_PILEUP_DETECT_EN
      d_prev_q <= d_q;
`endif
      if (ev_valid_q && evt.event_ready) ev_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (above) begin
            state_q <= S_RISE;
            peak_q  <= d_q;
            time_q  <= ts_r_q;
            width_q <= {{(WID_W-1){1'b0}}, 1'b1};
`ifdef PULSE_PILEUP_DETECT_EN
            falling_q <= 1'b0;
            pileup_q  <= 1'b0;
`endif
          end
        end

        S_RISE: begin
          if (above) begin
            // Strict compare: a repeated maximum keeps the first timestamp.
            if (d_q > peak_q) begin
              peak_q <= d_q;
              time_q <= ts_r_q;
            end
            if (width_q != WID_MAX) width_q <= width_q + 1'b1;
`ifdef PULSE_PILEUP_DETECT_EN
            if (fall_now) falling_q <= 1'b1;
            if (pile_now) pileup_q  <= 1'b1;
`endif
          end else begin
            if (buf_free) begin
              ev_valid_q <= 1'b1;
              ev_peak_q  <= peak_q;
              ev_time_q  <= time_q;
              ev_width_q <= width_q;
`ifdef PULSE_PILEUP_DETECT_EN
              ev_pileup_q <= pileup_q;
`endif
            end else if (lost_q != 16'hFFFF) begin
              lost_q <= lost_q + 16'd1;
            end
            state_q    <= (DEAD_TIME > 0) ? S_DEAD : S_IDLE;
            dead_cnt_q <= CNT_W'(DEAD_TIME - 1);
          end
        end

        S_DEAD: begin
          if (dead_cnt_q == '0) state_q <= S_IDLE;
          else                  dead_cnt_q <= dead_cnt_q - 1'b1;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign evt.event_valid = ev_valid_q;
  assign evt.event_peak  = ev_peak_q;
  assign evt.event_time  = ev_time_q;
  assign evt.event_width = ev_width_q;
  assign lost_count      = lost_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// ----------------------------------------------------------------------------
// tb_pulse_peak_detector
// Directed bench for pulse_peak_detector with hand-computed expectations.
// Each input sample is applied before a rising edge; outputs are observed
// 1 time unit after that edge.
// ----------------------------------------------------------------------------
module tb_pulse_peak_detector;
  localparam int DATA_W    = 16;
  localparam int TS_W      = 16;
  localparam int WID_W     = 8;
  localparam int DEAD_TIME = 8;

`ifdef PULSE_PILEUP_DETECT_EN
  localparam logic EXP_PILE = 1'b1;
`else
  localparam logic EXP_PILE = 1'b0;
`endif

  logic                     clk;
  logic                     reset;
  logic signed [DATA_W-1:0] input_data;
  logic signed [DATA_W-1:0] threshold;
  logic [15:0]              lost_count;

  int n_cmp = 0;
  int n_err = 0;

  pulse_peak_detector_if #(.DATA_W(DATA_W), .TS_W(TS_W), .WID_W(WID_W)) evt ();

  pulse_peak_detector #(
    .SIZE_FILTER_DATA(13), .DATA_W(DATA_W), .TS_W(TS_W), .WID_W(WID_W),
    .DEAD_TIME(DEAD_TIME), .PILEUP_HYST(4)
  ) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .evt(evt), .lost_count(lost_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic signed [DATA_W-1:0] v);
    input_data = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    input_data = 16'sd321;
    threshold  = 16'sd100;
    evt.event_ready = 1'b1;
    reset = 1'b0;
    #12;
    n_cmp++; if (evt.event_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", evt.event_valid); end
    n_cmp++; if (evt.event_peak !== 16'sd0) begin n_err++; $display("FAIL reset_peak: got %0d want 0", evt.event_peak); end
    n_cmp++; if (evt.event_time !== 16'd0) begin n_err++; $display("FAIL reset_time: got %0d want 0", evt.event_time); end
    n_cmp++; if (lost_count !== 16'd0) begin n_err++; $display("FAIL reset_lost: got %0d want 0", lost_count); end
  endtask

  task automatic test_triangle();
    threshold = 16'sd100;
    evt.event_ready = 1'b1;
    input_data = 16'sd0;
    do_reset();
    step(16'sd0); step(16'sd150); step(16'sd300); step(16'sd200); step(16'sd50);
    n_cmp++; if (evt.event_valid !== 1'b0) begin n_err++; $display("FAIL tri_valid_early: got %0b want 0", evt.event_valid); end
    step(16'sd50);
    n_cmp++; if (evt.event_valid !== 1'b1) begin n_err++; $display("FAIL tri_valid: got %0b want 1", evt.event_valid); end
    n_cmp++; if (evt.event_peak !== 16'sd300) begin n_err++; $display("FAIL tri_peak: got %0d want 300", evt.event_peak); end
    n_cmp++; if (evt.event_time !== 16'd3) begin n_err++; $display("FAIL tri_time: got %0d want 3", evt.event_time); end
    n_cmp++; if (evt.event_width !== 8'd3) begin n_err++; $display("FAIL tri_width: got %0d want 3", evt.event_width); end
    n_cmp++; if (evt.event_pileup !== 1'b0) begin n_err++; $display("FAIL tri_pileup: got %0b want 0", evt.event_pileup); end
    step(16'sd50);
    n_cmp++; if (evt.event_valid !== 1'b0) begin n_err++; $display("FAIL tri_valid_drop: got %0b want 0", evt.event_valid); end
  endtask

  task automatic test_pileup();
    threshold = 16'sd100;
    evt.event_ready = 1'b1;
    input_data = 16'sd0;
    do_reset();
    step(16'sd0); step(16'sd150); step(16'sd300); step(16'sd200); step(16'sd280);
    step(16'sd50); step(16'sd50);
    n_cmp++; if (evt.event_valid !== 1'b1) begin n_err++; $display("FAIL pile_valid: got %0b want 1", evt.event_valid); end
    n_cmp++; if (evt.event_peak !== 16'sd300) begin n_err++; $display("FAIL pile_peak: got %0d want 300", evt.event_peak); end
    n_cmp++; if (evt.event_time !== 16'd3) begin n_err++; $display("FAIL pile_time: got %0d want 3", evt.event_time); end
    n_cmp++; if (evt.event_width !== 8'd4) begin n_err++; $display("FAIL pile_width: got %0d want 4", evt.event_width); end
    n_cmp++; if (evt.event_pileup !== EXP_PILE) begin n_err++; $display("FAIL pile_flag: got %0b want %0b", evt.event_pileup, EXP_PILE); end
  endtask

  task automatic test_lost();
    threshold = 16'sd100;
    evt.event_ready = 1'b0;
    input_data = 16'sd0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      step(16'sd200);
      for (int i = 0; i < DEAD_TIME + 2; i++) step(16'sd0);
      n_cmp++; if (evt.event_time !== 16'd1) begin n_err++; $display("FAIL lost_hold_time[%0d]: got %0d want 1", p, evt.event_time); end
    end
    n_cmp++; if (evt.event_valid !== 1'b1) begin n_err++; $display("FAIL lost_valid: got %0b want 1", evt.event_valid); end
    n_cmp++; if (evt.event_peak !== 16'sd200) begin n_err++; $display("FAIL lost_peak: got %0d want 200", evt.event_peak); end
    n_cmp++; if (evt.event_width !== 8'd1) begin n_err++; $display("FAIL lost_width: got %0d want 1", evt.event_width); end
    n_cmp++; if (lost_count !== 16'd2) begin n_err++; $display("FAIL lost_count: got %0d want 2", lost_count); end
    evt.event_ready = 1'b1;
    step(16'sd0);
    n_cmp++; if (evt.event_valid !== 1'b0) begin n_err++; $display("FAIL lost_accept_drop: got %0b want 0", evt.event_valid); end
    n_cmp++; if (lost_count !== 16'd2) begin n_err++; $display("FAIL lost_count_after: got %0d want 2", lost_count); end
  endtask

  task automatic test_saturation();
    threshold = 16'sd0;
    evt.event_ready = 1'b1;
    input_data = 16'sd0;
    do_reset();
    step(16'sd0);
    for (int i = 0; i < 300; i++) step(16'sd500);
    step(16'sd0);
    n_cmp++; if (evt.event_valid !== 1'b0) begin n_err++; $display("FAIL sat_valid_early: got %0b want 0", evt.event_valid); end
    step(16'sd0);
    n_cmp++; if (evt.event_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid: got %0b want 1", evt.event_valid); end
    n_cmp++; if (evt.event_width !== 8'd255) begin n_err++; $display("FAIL sat_width: got %0d want 255", evt.event_width); end
    n_cmp++; if (evt.event_peak !== 16'sd500) begin n_err++; $display("FAIL sat_peak: got %0d want 500", evt.event_peak); end
    n_cmp++; if (evt.event_time !== 16'd2) begin n_err++; $display("FAIL sat_time: got %0d want 2", evt.event_time); end
  endtask

  task automatic test_negative();
    threshold = 16'sd0;
    evt.event_ready = 1'b1;
    input_data = -16'sd400;
    do_reset();
    step(-16'sd400);
    threshold = -16'sd300;
    step(-16'sd400); step(-16'sd200); step(-16'sd400); step(-16'sd400);
    n_cmp++; if (evt.event_valid !== 1'b1) begin n_err++; $display("FAIL neg_valid: got %0b want 1", evt.event_valid); end
    n_cmp++; if (evt.event_peak !== -16'sd200) begin n_err++; $display("FAIL neg_peak: got %0d want -200", evt.event_peak); end
    n_cmp++; if (evt.event_time !== 16'd3) begin n_err++; $display("FAIL neg_time: got %0d want 3", evt.event_time); end
    n_cmp++; if (evt.event_width !== 8'd1) begin n_err++; $display("FAIL neg_width: got %0d want 1", evt.event_width); end
  endtask

  task automatic test_reset_mid_pulse();
    logic seen;
    threshold = 16'sd100;
    evt.event_ready = 1'b0;
    input_data = 16'sd0;
    do_reset();
    step(16'sd0); step(16'sd200);
    for (int i = 0; i < DEAD_TIME + 2; i++) step(16'sd0);
    step(16'sd200); step(16'sd200); step(16'sd200);
    n_cmp++; if (evt.event_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %0b want 1", evt.event_valid); end
    reset = 1'b0;
    #1;
    n_cmp++; if (evt.event_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %0b want 0", evt.event_valid); end
    n_cmp++; if (evt.event_peak !== 16'sd0) begin n_err++; $display("FAIL mid_peak: got %0d want 0", evt.event_peak); end
    n_cmp++; if (evt.event_time !== 16'd0) begin n_err++; $display("FAIL mid_time: got %0d want 0", evt.event_time); end
    n_cmp++; if (evt.event_width !== 8'd0) begin n_err++; $display("FAIL mid_width: got %0d want 0", evt.event_width); end
    input_data = 16'sd0;
    evt.event_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(16'sd0);
      if (evt.event_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_record: got %0b want 0", seen); end
    n_cmp++; if (lost_count !== 16'd0) begin n_err++; $display("FAIL mid_lost: got %0d want 0", lost_count); end
    // Six edges already elapsed since release, so the next sample is stamped 7.
    step(16'sd250); step(16'sd0); step(16'sd0);
    n_cmp++; if (evt.event_valid !== 1'b1) begin n_err++; $display("FAIL mid_new_valid: got %0b want 1", evt.event_valid); end
    n_cmp++; if (evt.event_time !== 16'd7) begin n_err++; $display("FAIL mid_new_time: got %0d want 7", evt.event_time); end
    n_cmp++; if (evt.event_peak !== 16'sd250) begin n_err++; $display("FAIL mid_new_peak: got %0d want 250", evt.event_peak); end
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_pileup();
    test_lost();
    test_saturation();
    test_negative();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_peak_detector.md
# pulse_peak_detector

Back-end consumer of the filtered pulse stream: it takes the signed `output_data_v2`-style sample stream from the filter chain, applies a threshold, and tracks each pulse. It emits one event record per pulse: peak amplitude, peak timestamp, width above threshold and a pile-up flag. Records leave through a one-deep valid/ready buffer. Paired with `exp_sig_gen` on the bench, it closes the loop from the generated signal to the measured pulse parameters.

## Interface
Parameters:
- `DATA_W`, `SIZE_FILTER_DATA+3`: width of the signed input sample.
- `TS_W`, 16: width of the free-running timestamp.
- `WID_W`, 8: width of the pulse-width field.
- `DEAD_TIME`, 8: cycles spent in DEAD after each pulse; 0 is legal.
- `PILEUP_HYST`, 4: rise after a local minimum that flags pile-up.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `input_data`  in  `DATA_W`  signed filtered sample, one per clock.
- `threshold`  in  `DATA_W`  signed trigger level; quasi-static.
- `event_ready`  in  1  consumer accepts the record.
- `event_valid`  out  1  record valid.
- `event_peak`  out  `DATA_W`  signed peak amplitude.
- `event_time`  out  `TS_W`  timestamp of the peak sample.
- `event_width`  out  `WID_W`  samples above threshold, saturating.
- `event_pileup`  out  1  pile-up seen within the pulse.
- `lost_count`  out  16  records dropped because the buffer was full; saturating.

## Operation
- Input stage: each edge registers `input_data` into `d_r`. A free-running counter `ts` (wraps modulo 2^TS_W) is captured into `ts_r` alongside it. The FSM uses only `d_r` and `ts_r`.
- All comparisons are signed.
- IDLE:
  - `d_r > threshold` → RISE.
  - On entry to RISE: peak=`d_r`, time=`ts_r`, width=1, pileup=0, falling=0.
- RISE, while `d_r > threshold`:
  - `d_r > peak`: update peak and time. Ties keep the first maximum.
  - width += 1, saturating at 2^WID_W-1.
  - Pile-up tracking:
    - `d_r < d_prev` sets falling.
    - If falling and `d_r > d_prev + PILEUP_HYST` (computed at DATA_W+1 bits), pileup=1.
- RISE exit, when `d_r <= threshold`:
  - Record is offered to the output buffer.
  - Go to DEAD if `DEAD_TIME>0`, else IDLE.
- DEAD:
  - Counts `DEAD_TIME` cycles, ignores input, then → IDLE.
  - If the input is still above threshold on return to IDLE, a new pulse starts on the next cycle.
- Output buffer, one record deep:
  - Loaded if empty, or if `event_valid && event_ready` in the same cycle.
  - Otherwise the new record is dropped, the buffer keeps the old record, and `lost_count` += 1 (saturates at 0xFFFF).
- Handshake:
  - Transfer happens on an edge with `event_valid && event_ready`.
  - Record fields are stable while `event_valid` is high and not yet accepted.
- `threshold` changes are honoured from the next comparison; no pulse is retroactively split.

## Timing
- Reset values (asynchronous, active-low): every output = 0, FSM=IDLE, `ts`=0, `d_r`=0, buffer empty.
- Reset mid-pulse discards the pulse silently: no record, no loss count.
- Latency: sample presented before edge k is in `d_r` after k and decided on edge k+1.
  - The first sub-threshold sample presented before edge k makes `event_valid` rise after edge k+1.
- `event_time` equals the `ts` value at the edge that captured the peak sample into `d_r`.
  - `ts` is 1 after the first edge out of reset.
- `event_valid` drops the cycle after acceptance, unless it is reloaded on that same edge.
- Minimum pulse: one sample above threshold gives width=1.
- Back-to-back throughput: one record per pulse with no bubbles, provided `event_ready` is held high.

## Configuration
- `PULSE_PILEUP_DETECT_EN` defined:
  - Falling/pile-up tracking is built.
  - `event_pileup` reports as above.
- Undefined:
  - The tracking logic and the `d_prev` register are omitted.
  - `event_pileup` is constant 0.
  - All other behaviour is identical.

## Test plan
- Triangle pulse, threshold=100. Samples 0,150,300,200,50 presented at edges 1–5, `event_ready`=1.
  - Expect one record: peak=300, time=3, width=3, pileup=0.
  - `event_valid` high after edge 6.
- Double-hump pulse, threshold=100: 150,300,200,280,50.
  - With `PULSE_PILEUP_DETECT_EN`: peak=300, width=4, pileup=1.
  - Without it: same record, pileup=0.
- `event_ready`=0, three pulses each separated by `DEAD_TIME`+2 idle samples.
  - Expect first record held stable and `lost_count`=2.
  - Raise `event_ready`: record 1 is accepted and `event_valid` drops.
- Input held at 500 for 300 cycles, threshold=0, WID_W=8.
  - Expect width=255 (saturated) and peak=500 with time equal to the first-sample timestamp (ties keep first).
- Negative input −200 at threshold=−300.
  - Expect a pulse to be detected (signed compare); peak=−200.
- Reset asserted in RISE after 2 samples above threshold.
  - Expect all outputs 0 immediately and no record after release.
  - A subsequent pulse reports `ts` restarted from 1.
